// File: rtl/swervolf_ram_arb.sv
// Two-master to one-slave AXI4 arbiter in front of the SweRVolf on-chip RAM.
// One transaction (AW+W+B or AR+R) is in flight at a time. Grants rotate
// round-robin between masters. A master that has both AW and AR pending
// alternates between write and read.
module swervolf_ram_arb #(
  parameter int ID_W = 6,
  parameter int DW   = 64
) (
  input  logic            clk,
  input  logic            rstn,
  // master 0
  input  logic [ID_W-1:0] i_m0_awid,
  input  logic [31:0]     i_m0_awaddr,
  input  logic [7:0]      i_m0_awlen,
  input  logic [2:0]      i_m0_awsize,
  input  logic [1:0]      i_m0_awburst,
  input  logic            i_m0_awvalid,
  output logic            o_m0_awready,
  input  logic [ID_W-1:0] i_m0_arid,
  input  logic [31:0]     i_m0_araddr,
  input  logic [7:0]      i_m0_arlen,
  input  logic [2:0]      i_m0_arsize,
  input  logic [1:0]      i_m0_arburst,
  input  logic            i_m0_arvalid,
  output logic            o_m0_arready,
  input  logic [DW-1:0]   i_m0_wdata,
  input  logic [DW/8-1:0] i_m0_wstrb,
  input  logic            i_m0_wlast,
  input  logic            i_m0_wvalid,
  output logic            o_m0_wready,
  output logic [ID_W-1:0] o_m0_bid,
  output logic [1:0]      o_m0_bresp,
  output logic            o_m0_bvalid,
  input  logic            i_m0_bready,
  output logic [ID_W-1:0] o_m0_rid,
  output logic [DW-1:0]   o_m0_rdata,
  output logic [1:0]      o_m0_rresp,
  output logic            o_m0_rlast,
  output logic            o_m0_rvalid,
  input  logic            i_m0_rready,
  // master 1
  input  logic [ID_W-1:0] i_m1_awid,
  input  logic [31:0]     i_m1_awaddr,
  input  logic [7:0]      i_m1_awlen,
  input  logic [2:0]      i_m1_awsize,
  input  logic [1:0]      i_m1_awburst,
  input  logic            i_m1_awvalid,
  output logic            o_m1_awready,
  input  logic [ID_W-1:0] i_m1_arid,
  input  logic [31:0]     i_m1_araddr,
  input  logic [7:0]      i_m1_arlen,
  input  logic [2:0]      i_m1_arsize,
  input  logic [1:0]      i_m1_arburst,
  input  logic            i_m1_arvalid,
  output logic            o_m1_arready,
  input  logic [DW-1:0]   i_m1_wdata,
  input  logic [DW/8-1:0] i_m1_wstrb,
  input  logic            i_m1_wlast,
  input  logic            i_m1_wvalid,
  output logic            o_m1_wready,
  output logic [ID_W-1:0] o_m1_bid,
  output logic [1:0]      o_m1_bresp,
  output logic            o_m1_bvalid,
  input  logic            i_m1_bready,
  output logic [ID_W-1:0] o_m1_rid,
  output logic [DW-1:0]   o_m1_rdata,
  output logic [1:0]      o_m1_rresp,
  output logic            o_m1_rlast,
  output logic            o_m1_rvalid,
  input  logic            i_m1_rready,
  // slave (RAM)
  output logic [ID_W-1:0] o_s_awid,
  output logic [31:0]     o_s_awaddr,
  output logic [7:0]      o_s_awlen,
  output logic [2:0]      o_s_awsize,
  output logic [1:0]      o_s_awburst,
  output logic            o_s_awvalid,
  input  logic            i_s_awready,
  output logic [ID_W-1:0] o_s_arid,
  output logic [31:0]     o_s_araddr,
  output logic [7:0]      o_s_arlen,
  output logic [2:0]      o_s_arsize,
  output logic [1:0]      o_s_arburst,
  output logic            o_s_arvalid,
  input  logic            i_s_arready,
  output logic [DW-1:0]   o_s_wdata,
  output logic [DW/8-1:0] o_s_wstrb,
  output logic            o_s_wlast,
  output logic            o_s_wvalid,
  input  logic            i_s_wready,
  input  logic [ID_W-1:0] i_s_bid,
  input  logic [1:0]      i_s_bresp,
  input  logic            i_s_bvalid,
  output logic            o_s_bready,
  input  logic [ID_W-1:0] i_s_rid,
  input  logic [DW-1:0]   i_s_rdata,
  input  logic [1:0]      i_s_rresp,
  input  logic            i_s_rlast,
  input  logic            i_s_rvalid,
  output logic            o_s_rready,
  // status
  output logic            o_busy,
  output logic            o_owner
);

  typedef enum logic [1:0] {IDLE, WR, WR_RESP, RD} state_t;

  state_t     state_reg;
  logic       owner_reg;
  logic       rr_ptr_reg;
  logic       aw_done_reg;
  logic       w_done_reg;
  logic       ar_done_reg;
  logic [1:0] last_op_reg;   // per master: 1 = last grant was a write

  logic [1:0] m_awvalid, m_arvalid, m_wvalid, m_bready, m_rready;
  logic [1:0] m_awready, m_arready, m_wready, m_bvalid, m_rvalid;
  logic [1:0] req;
  logic       win;
  logic       pick_wr;
  logic       s_aw_hs, s_w_hs, s_b_hs, s_ar_hs, s_r_hs;

  assign m_awvalid = {i_m1_awvalid, i_m0_awvalid};
  assign m_arvalid = {i_m1_arvalid, i_m0_arvalid};
  assign m_wvalid  = {i_m1_wvalid,  i_m0_wvalid};
  assign m_bready  = {i_m1_bready,  i_m0_bready};
  assign m_rready  = {i_m1_rready,  i_m0_rready};

  // Arbitration: a lone requester wins, a tie goes to rr_ptr. Within the
  // winner, a simultaneous AW/AR pair is resolved against its last op.
  assign req     = m_awvalid | m_arvalid;
  assign win     = (req[0] && req[1]) ? rr_ptr_reg : req[1];
  assign pick_wr = (m_awvalid[win] && m_arvalid[win]) ? !last_op_reg[win]
                                                      : m_awvalid[win];

  // Slave-side request channels carry the owner's payload; valids are gated
  // by state so nothing reaches the RAM in IDLE or on an unused channel.
  assign o_s_awid    = owner_reg ? i_m1_awid    : i_m0_awid;
  assign o_s_awaddr  = owner_reg ? i_m1_awaddr  : i_m0_awaddr;
  assign o_s_awlen   = owner_reg ? i_m1_awlen   : i_m0_awlen;
  assign o_s_awsize  = owner_reg ? i_m1_awsize  : i_m0_awsize;
  assign o_s_awburst = owner_reg ? i_m1_awburst : i_m0_awburst;
  assign o_s_awvalid = (state_reg == WR) && !aw_done_reg && m_awvalid[owner_reg];

  assign o_s_wdata  = owner_reg ? i_m1_wdata : i_m0_wdata;
  assign o_s_wstrb  = owner_reg ? i_m1_wstrb : i_m0_wstrb;
  assign o_s_wlast  = owner_reg ? i_m1_wlast : i_m0_wlast;
  assign o_s_wvalid = (state_reg == WR) && !w_done_reg && m_wvalid[owner_reg];

  assign o_s_bready = (state_reg == WR_RESP) && m_bready[owner_reg];

  assign o_s_arid    = owner_reg ? i_m1_arid    : i_m0_arid;
  assign o_s_araddr  = owner_reg ? i_m1_araddr  : i_m0_araddr;
  assign o_s_arlen   = owner_reg ? i_m1_arlen   : i_m0_arlen;
  assign o_s_arsize  = owner_reg ? i_m1_arsize  : i_m0_arsize;
  assign o_s_arburst = owner_reg ? i_m1_arburst : i_m0_arburst;
  assign o_s_arvalid = (state_reg == RD) && !ar_done_reg && m_arvalid[owner_reg];

  assign o_s_rready = (state_reg == RD) && m_rready[owner_reg];

  assign s_aw_hs = o_s_awvalid && i_s_awready;
  assign s_w_hs  = o_s_wvalid  && i_s_wready;
  assign s_b_hs  = i_s_bvalid  && o_s_bready;
  assign s_ar_hs = o_s_arvalid && i_s_arready;
  assign s_r_hs  = i_s_rvalid  && o_s_rready;

  // Master-side handshake signals: only the owner ever sees a ready or valid.
  for (genvar gi = 0; gi < 2; gi++) begin : g_master
    logic own;
    assign own           = (owner_reg == 1'(gi));
    assign m_awready[gi] = own && (state_reg == WR) && !aw_done_reg && i_s_awready;
    assign m_wready[gi]  = own && (state_reg == WR) && !w_done_reg && i_s_wready;
    assign m_bvalid[gi]  = own && (state_reg == WR_RESP) && i_s_bvalid;
    assign m_arready[gi] = own && (state_reg == RD) && !ar_done_reg && i_s_arready;
    assign m_rvalid[gi]  = own && (state_reg == RD) && i_s_rvalid;
  end

  assign o_m0_awready = m_awready[0];
  assign o_m1_awready = m_awready[1];
  assign o_m0_wready  = m_wready[0];
  assign o_m1_wready  = m_wready[1];
  assign o_m0_bvalid  = m_bvalid[0];
  assign o_m1_bvalid  = m_bvalid[1];
  assign o_m0_arready = m_arready[0];
  assign o_m1_arready = m_arready[1];
  assign o_m0_rvalid  = m_rvalid[0];
  assign o_m1_rvalid  = m_rvalid[1];

  // Response payloads are broadcast untouched; the valids select the owner.
  assign o_m0_bid   = i_s_bid;
  assign o_m1_bid   = i_s_bid;
  assign o_m0_bresp = i_s_bresp;
  assign o_m1_bresp = i_s_bresp;
  assign o_m0_rid   = i_s_rid;
  assign o_m1_rid   = i_s_rid;
  assign o_m0_rdata = i_s_rdata;
  assign o_m1_rdata = i_s_rdata;
  assign o_m0_rresp = i_s_rresp;
  assign o_m1_rresp = i_s_rresp;
  assign o_m0_rlast = i_s_rlast;
  assign o_m1_rlast = i_s_rlast;

  assign o_busy  = (state_reg != IDLE);
  assign o_owner = owner_reg;

  // Grant FSM: arbitrate in IDLE, then track AW/W/AR completion per transaction.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= IDLE;
      owner_reg   <= 1'b0;
      rr_ptr_reg  <= 1'b0;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
      ar_done_reg <= 1'b0;
      last_op_reg <= 2'b00;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|req) begin
            owner_reg        <= win;
            rr_ptr_reg       <= !win;
            last_op_reg[win] <= pick_wr;
            aw_done_reg      <= 1'b0;
            w_done_reg       <= 1'b0;
            ar_done_reg      <= 1'b0;
            state_reg        <= pick_wr ? WR : RD;
          end
        end
        WR: begin
          if (s_aw_hs) aw_done_reg <= 1'b1;
          if (s_w_hs && o_s_wlast) w_done_reg <= 1'b1;
          if ((aw_done_reg || s_aw_hs) && (w_done_reg || (s_w_hs && o_s_wlast)))
            state_reg <= WR_RESP;
        end
        WR_RESP: begin
          if (s_b_hs) begin
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            state_reg   <= IDLE;
          end
        end
        RD: begin
          if (s_ar_hs) ar_done_reg <= 1'b1;
          if (s_r_hs && i_s_rlast) begin
            ar_done_reg <= 1'b0;
            state_reg   <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_swervolf_ram_arb.sv
// Directed testbench for swervolf_ram_arb with a small AXI RAM slave model.
module tb_swervolf_ram_arb;
  localparam int ID_W = 6;
  localparam int DW   = 64;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // master-side stimulus and observation, indexed by master
  logic [ID_W-1:0] m_awid[2], m_arid[2];
  logic [31:0]     m_awaddr[2], m_araddr[2];
  logic [7:0]      m_awlen[2], m_arlen[2];
  logic [2:0]      m_awsize[2], m_arsize[2];
  logic [1:0]      m_awburst[2], m_arburst[2];
  logic            m_awvalid[2], m_arvalid[2], m_wvalid[2], m_wlast[2];
  logic            m_bready[2], m_rready[2];
  logic [DW-1:0]   m_wdata[2];
  logic [DW/8-1:0] m_wstrb[2];
  logic            m_awready[2], m_arready[2], m_wready[2];
  logic            m_bvalid[2], m_rvalid[2], m_rlast[2];
  logic [ID_W-1:0] m_bid[2], m_rid[2];
  logic [1:0]      m_bresp[2], m_rresp[2];
  logic [DW-1:0]   m_rdata[2];

  // slave side
  logic [ID_W-1:0] s_awid, s_arid, s_bid, s_rid;
  logic [31:0]     s_awaddr, s_araddr;
  logic [7:0]      s_awlen, s_arlen;
  logic [2:0]      s_awsize, s_arsize;
  logic [1:0]      s_awburst, s_arburst, s_bresp, s_rresp;
  logic            s_awvalid, s_awready, s_arvalid, s_arready;
  logic [DW-1:0]   s_wdata, s_rdata;
  logic [DW/8-1:0] s_wstrb;
  logic            s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
  logic            s_rlast, s_rvalid, s_rready;
  logic            busy, owner;

  swervolf_ram_arb #(.ID_W(ID_W), .DW(DW)) dut (
    .clk(clk), .rstn(rstn),
    .i_m0_awid(m_awid[0]), .i_m0_awaddr(m_awaddr[0]), .i_m0_awlen(m_awlen[0]),
    .i_m0_awsize(m_awsize[0]), .i_m0_awburst(m_awburst[0]), .i_m0_awvalid(m_awvalid[0]),
    .o_m0_awready(m_awready[0]),
    .i_m0_arid(m_arid[0]), .i_m0_araddr(m_araddr[0]), .i_m0_arlen(m_arlen[0]),
    .i_m0_arsize(m_arsize[0]), .i_m0_arburst(m_arburst[0]), .i_m0_arvalid(m_arvalid[0]),
    .o_m0_arready(m_arready[0]),
    .i_m0_wdata(m_wdata[0]), .i_m0_wstrb(m_wstrb[0]), .i_m0_wlast(m_wlast[0]),
    .i_m0_wvalid(m_wvalid[0]), .o_m0_wready(m_wready[0]),
    .o_m0_bid(m_bid[0]), .o_m0_bresp(m_bresp[0]), .o_m0_bvalid(m_bvalid[0]),
    .i_m0_bready(m_bready[0]),
    .o_m0_rid(m_rid[0]), .o_m0_rdata(m_rdata[0]), .o_m0_rresp(m_rresp[0]),
    .o_m0_rlast(m_rlast[0]), .o_m0_rvalid(m_rvalid[0]), .i_m0_rready(m_rready[0]),
    .i_m1_awid(m_awid[1]), .i_m1_awaddr(m_awaddr[1]), .i_m1_awlen(m_awlen[1]),
    .i_m1_awsize(m_awsize[1]), .i_m1_awburst(m_awburst[1]), .i_m1_awvalid(m_awvalid[1]),
    .o_m1_awready(m_awready[1]),
    .i_m1_arid(m_arid[1]), .i_m1_araddr(m_araddr[1]), .i_m1_arlen(m_arlen[1]),
    .i_m1_arsize(m_arsize[1]), .i_m1_arburst(m_arburst[1]), .i_m1_arvalid(m_arvalid[1]),
    .o_m1_arready(m_arready[1]),
    .i_m1_wdata(m_wdata[1]), .i_m1_wstrb(m_wstrb[1]), .i_m1_wlast(m_wlast[1]),
    .i_m1_wvalid(m_wvalid[1]), .o_m1_wready(m_wready[1]),
    .o_m1_bid(m_bid[1]), .o_m1_bresp(m_bresp[1]), .o_m1_bvalid(m_bvalid[1]),
    .i_m1_bready(m_bready[1]),
    .o_m1_rid(m_rid[1]), .o_m1_rdata(m_rdata[1]), .o_m1_rresp(m_rresp[1]),
    .o_m1_rlast(m_rlast[1]), .o_m1_rvalid(m_rvalid[1]), .i_m1_rready(m_rready[1]),
    .o_s_awid(s_awid), .o_s_awaddr(s_awaddr), .o_s_awlen(s_awlen), .o_s_awsize(s_awsize),
    .o_s_awburst(s_awburst), .o_s_awvalid(s_awvalid), .i_s_awready(s_awready),
    .o_s_arid(s_arid), .o_s_araddr(s_araddr), .o_s_arlen(s_arlen), .o_s_arsize(s_arsize),
    .o_s_arburst(s_arburst), .o_s_arvalid(s_arvalid), .i_s_arready(s_arready),
    .o_s_wdata(s_wdata), .o_s_wstrb(s_wstrb), .o_s_wlast(s_wlast), .o_s_wvalid(s_wvalid),
    .i_s_wready(s_wready),
    .i_s_bid(s_bid), .i_s_bresp(s_bresp), .i_s_bvalid(s_bvalid), .o_s_bready(s_bready),
    .i_s_rid(s_rid), .i_s_rdata(s_rdata), .i_s_rresp(s_rresp), .i_s_rlast(s_rlast),
    .i_s_rvalid(s_rvalid), .o_s_rready(s_rready),
    .o_busy(busy), .o_owner(owner)
  );

  // ---------------- RAM slave model (reset by the same rstn) ----------------
  logic [DW-1:0]   mem[0:255];
  logic            sl_aw_have, sl_b_pend, sl_r_act;
  logic [7:0]      sl_wptr, sl_rptr, sl_rcnt, sl_rlen, sl_raddr;
  logic [ID_W-1:0] sl_bid, sl_rid;
  int              sl_wbeats = 0;

  assign s_awready = !sl_aw_have && !sl_b_pend;
  assign s_wready  = sl_aw_have;
  assign s_bvalid  = sl_b_pend;
  assign s_bid     = sl_bid;
  assign s_bresp   = 2'b00;
  assign s_arready = !sl_r_act;
  assign sl_raddr  = sl_rptr + sl_rcnt;
  assign s_rvalid  = sl_r_act;
  assign s_rdata   = mem[sl_raddr];
  assign s_rlast   = sl_r_act && (sl_rcnt == sl_rlen);
  assign s_rid     = sl_rid;
  assign s_rresp   = 2'b00;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 256; i++) mem[i] <= {32'hD0D0_0000, 24'h0, 8'(i)};
      sl_aw_have <= 1'b0; sl_b_pend <= 1'b0; sl_r_act <= 1'b0;
      sl_wptr <= 8'h0; sl_rptr <= 8'h0; sl_rcnt <= 8'h0; sl_rlen <= 8'h0;
      sl_bid <= '0; sl_rid <= '0;
    end else begin
      if (s_awvalid && s_awready) begin
        sl_aw_have <= 1'b1; sl_wptr <= s_awaddr[10:3]; sl_bid <= s_awid;
      end
      if (s_wvalid && s_wready) begin
        mem[sl_wptr] <= s_wdata;
        sl_wptr      <= sl_wptr + 8'd1;
        sl_wbeats    <= sl_wbeats + 1;
        if (s_wlast) begin sl_aw_have <= 1'b0; sl_b_pend <= 1'b1; end
      end
      if (s_bvalid && s_bready) sl_b_pend <= 1'b0;
      if (s_arvalid && s_arready) begin
        sl_r_act <= 1'b1; sl_rptr <= s_araddr[10:3]; sl_rlen <= s_arlen;
        sl_rcnt <= 8'h0; sl_rid <= s_arid;
      end
      if (s_rvalid && s_rready) begin
        if (s_rlast) sl_r_act <= 1'b0;
        else sl_rcnt <= sl_rcnt + 8'd1;
      end
    end
  end

  // cycle counter and per-master activity counter
  int cyc = 0;
  int act_cnt[2] = '{0, 0};
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++)
      if (m_awready[m] || m_arready[m] || m_wready[m] || m_bvalid[m] || m_rvalid[m])
        act_cnt[m] <= act_cnt[m] + 1;
  end

  // ---------------- per-master driver results ----------------
  int              aw_cyc[2], ar_cyc[2], b_cyc[2], r_end_cyc[2], rbeats[2], rlast_cnt[2];
  logic [DW-1:0]   rdat[2][16];
  logic [1:0]      bresp_got[2];
  logic [ID_W-1:0] bid_got[2], rid_got[2];
  bit              wready_early[2], rlast_bad[2], to_flag[2];
  bit              busy_bad;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic clear_master(input int m);
    m_awvalid[m] = 0; m_arvalid[m] = 0; m_wvalid[m] = 0; m_wlast[m] = 0;
    m_bready[m] = 0; m_rready[m] = 0; m_wdata[m] = '0; m_wstrb[m] = '1;
    m_awid[m] = '0; m_arid[m] = '0; m_awaddr[m] = '0; m_araddr[m] = '0;
    m_awlen[m] = '0; m_arlen[m] = '0; m_awsize[m] = 3'd3; m_arsize[m] = 3'd3;
    m_awburst[m] = 2'd1; m_arburst[m] = 2'd1;
  endtask

  task automatic do_reset();
    rstn = 0;
    clear_master(0); clear_master(1);
    repeat (2) @(posedge clk);
    #2 rstn = 1;
    @(posedge clk); #1;
  endtask

  // Drives one write and/or one read on master m; beat k of the write carries wbase*(k+1).
  task automatic run_master(input int m, input bit wr, input bit rd,
                            input logic [31:0] waddr, input int wlen, input logic [63:0] wbase,
                            input int w_lead, input logic [31:0] raddr, input int rlen,
                            input bit rtog, input logic [ID_W-1:0] id, input bit chk_busy);
    bit aw_ok, w_ok, b_ok, ar_ok, r_ok;
    int wb;
    aw_ok = !wr; w_ok = !wr; b_ok = !wr; ar_ok = !rd; r_ok = !rd; wb = 0;
    rbeats[m] = 0; rlast_cnt[m] = 0; rlast_bad[m] = 0; wready_early[m] = 0; to_flag[m] = 0;
    m_awid[m] = id; m_awaddr[m] = waddr; m_awlen[m] = 8'(wlen);
    m_arid[m] = id; m_araddr[m] = raddr; m_arlen[m] = 8'(rlen);
    for (int t = 0; t < 400; t++) begin
      m_awvalid[m] = !aw_ok && (t >= w_lead);
      m_wvalid[m]  = !w_ok;
      m_wdata[m]   = wbase * 64'(wb + 1);
      m_wlast[m]   = (wb == wlen);
      m_bready[m]  = !b_ok;
      m_arvalid[m] = !ar_ok;
      m_rready[m]  = !r_ok && (!rtog || (t % 2 == 0));
      if (b_ok && r_ok) break;
      @(negedge clk);
      if (t < w_lead && m_wready[m]) wready_early[m] = 1;
      if (chk_busy && t >= 1 && !b_ok && !busy) busy_bad = 1;
      if (m_awvalid[m] && m_awready[m]) begin aw_ok = 1; aw_cyc[m] = cyc; end
      if (m_wvalid[m] && m_wready[m]) begin
        if (m_wlast[m]) w_ok = 1; else wb++;
      end
      if (m_bvalid[m] && m_bready[m]) begin
        b_ok = 1; b_cyc[m] = cyc; bresp_got[m] = m_bresp[m]; bid_got[m] = m_bid[m];
        $display("[TB] m%0d write addr=%h beats=%0d bresp=%0d cyc=%0d", m, waddr, wlen + 1, m_bresp[m], cyc);
      end
      if (m_arvalid[m] && m_arready[m]) begin ar_ok = 1; ar_cyc[m] = cyc; end
      if (m_rvalid[m] && m_rready[m]) begin
        if (rbeats[m] < 16) rdat[m][rbeats[m]] = m_rdata[m];
        rid_got[m] = m_rid[m];
        if (m_rlast[m]) begin
          rlast_cnt[m]++;
          if (rbeats[m] != rlen) rlast_bad[m] = 1;
          r_ok = 1; r_end_cyc[m] = cyc;
          $display("[TB] m%0d read addr=%h beats=%0d cyc=%0d", m, raddr, rbeats[m] + 1, cyc);
        end
        rbeats[m]++;
      end
      @(posedge clk); #1;
    end
    m_awvalid[m] = 0; m_wvalid[m] = 0; m_bready[m] = 0; m_arvalid[m] = 0; m_rready[m] = 0;
    if (!(b_ok && r_ok)) to_flag[m] = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests_run++; if (owner !== 1'b0) begin tests_failed++; $display("FAIL reset_owner: got %b want 0", owner); end
    tests_run++;
    if ({m_awready[0], m_arready[0], m_wready[0], m_bvalid[0], m_rvalid[0],
         m_awready[1], m_arready[1], m_wready[1], m_bvalid[1], m_rvalid[1]} !== 10'h0) begin
      tests_failed++; $display("FAIL reset_master_hs: some master ready/valid nonzero, want all 0");
    end
    tests_run++;
    if ({s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready} !== 5'h0) begin
      tests_failed++; $display("FAIL reset_slave_hs: got %b want 00000", {s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready});
    end
    $display("[TB] reset state checked");
  endtask

  task automatic test_single_write();
    int wb0, act1;
    do_reset();
    wb0 = sl_wbeats; act1 = act_cnt[1]; busy_bad = 0;
    run_master(0, 1, 0, 32'h100, 1, 64'h11, 0, 32'h0, 0, 0, 6'h03, 1);
    @(negedge clk);
    tests_run++; if (to_flag[0] !== 1'b0) begin tests_failed++; $display("FAIL wr_timeout: got %b want 0", to_flag[0]); end
    tests_run++; if (sl_wbeats - wb0 != 2) begin tests_failed++; $display("FAIL wr_beats: got %0d want 2", sl_wbeats - wb0); end
    tests_run++; if (mem[8'h20] !== 64'h11) begin tests_failed++; $display("FAIL wr_data0: got %h want 11", mem[8'h20]); end
    tests_run++; if (mem[8'h21] !== 64'h22) begin tests_failed++; $display("FAIL wr_data1: got %h want 22", mem[8'h21]); end
    tests_run++; if (bresp_got[0] !== 2'b00) begin tests_failed++; $display("FAIL wr_bresp: got %0d want 0", bresp_got[0]); end
    tests_run++; if (bid_got[0] !== 6'h03) begin tests_failed++; $display("FAIL wr_bid: got %h want 03", bid_got[0]); end
    tests_run++; if (busy_bad !== 1'b0) begin tests_failed++; $display("FAIL wr_busy_during: got low want high"); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL wr_busy_after: got %b want 0", busy); end
    tests_run++; if (act_cnt[1] != act1) begin tests_failed++; $display("FAIL wr_m1_quiet: got %0d want 0 active cycles", act_cnt[1] - act1); end
  endtask

  task automatic test_round_robin();
    int first_ar, first_end;
    logic [63:0] first_data;
    do_reset();
    fork
      begin
        run_master(0, 0, 1, 32'h0, 0, 64'h0, 0, 32'h200, 0, 0, 6'h05, 0);
        first_ar = ar_cyc[0]; first_end = r_end_cyc[0]; first_data = rdat[0][0];
        run_master(0, 0, 1, 32'h0, 0, 64'h0, 0, 32'h208, 0, 0, 6'h05, 0);
      end
      run_master(1, 0, 1, 32'h0, 0, 64'h0, 0, 32'h210, 0, 0, 6'h09, 0);
    join
    tests_run++; if (to_flag[0] || to_flag[1]) begin tests_failed++; $display("FAIL rr_timeout: got %b%b want 00", to_flag[1], to_flag[0]); end
    tests_run++; if (!(first_ar < ar_cyc[1])) begin tests_failed++; $display("FAIL rr_first_m0: m0 ar cyc %0d m1 ar cyc %0d want m0 earlier", first_ar, ar_cyc[1]); end
    tests_run++; if (ar_cyc[1] != first_end + 2) begin tests_failed++; $display("FAIL rr_gap: m1 ar cyc %0d want %0d", ar_cyc[1], first_end + 2); end
    tests_run++; if (!(ar_cyc[1] < ar_cyc[0])) begin tests_failed++; $display("FAIL rr_second_m1: m1 ar cyc %0d m0 ar cyc %0d want m1 earlier", ar_cyc[1], ar_cyc[0]); end
    tests_run++; if (first_data !== 64'hD0D0_0000_0000_0040) begin tests_failed++; $display("FAIL rr_m0_data: got %h want d0d0000000000040", first_data); end
    tests_run++; if (rdat[1][0] !== 64'hD0D0_0000_0000_0042) begin tests_failed++; $display("FAIL rr_m1_data: got %h want d0d0000000000042", rdat[1][0]); end
    tests_run++; if (rdat[0][0] !== 64'hD0D0_0000_0000_0041) begin tests_failed++; $display("FAIL rr_m0_data2: got %h want d0d0000000000041", rdat[0][0]); end
    tests_run++; if (rid_got[1] !== 6'h09) begin tests_failed++; $display("FAIL rr_rid: got %h want 09", rid_got[1]); end
  endtask

  task automatic test_rw_alternate();
    do_reset();
    run_master(0, 1, 1, 32'h300, 0, 64'h33, 0, 32'h300, 0, 0, 6'h11, 0);
    tests_run++; if (to_flag[0]) begin tests_failed++; $display("FAIL alt1_timeout: got 1 want 0"); end
    tests_run++; if (ar_cyc[0] != b_cyc[0] + 2) begin tests_failed++; $display("FAIL alt1_order: ar cyc %0d want %0d (after B)", ar_cyc[0], b_cyc[0] + 2); end
    tests_run++; if (rdat[0][0] !== 64'h33) begin tests_failed++; $display("FAIL alt1_data: got %h want 33", rdat[0][0]); end
    run_master(0, 1, 1, 32'h308, 0, 64'h44, 0, 32'h308, 0, 0, 6'h12, 0);
    tests_run++; if (to_flag[0]) begin tests_failed++; $display("FAIL alt2_timeout: got 1 want 0"); end
    tests_run++; if (!(b_cyc[0] < ar_cyc[0])) begin tests_failed++; $display("FAIL alt2_order: b cyc %0d ar cyc %0d want write first", b_cyc[0], ar_cyc[0]); end
    tests_run++; if (rdat[0][0] !== 64'h44) begin tests_failed++; $display("FAIL alt2_data: got %h want 44", rdat[0][0]); end
  endtask

  task automatic test_w_before_aw();
    do_reset();
    run_master(1, 1, 0, 32'h180, 1, 64'h5A, 3, 32'h0, 0, 0, 6'h2A, 0);
    tests_run++; if (to_flag[1]) begin tests_failed++; $display("FAIL wlead_timeout: got 1 want 0"); end
    tests_run++; if (wready_early[1] !== 1'b0) begin tests_failed++; $display("FAIL wlead_wready: got 1 before grant want 0"); end
    tests_run++; if (bid_got[1] !== 6'h2A) begin tests_failed++; $display("FAIL wlead_bid: got %h want 2a", bid_got[1]); end
    tests_run++; if (owner !== 1'b1) begin tests_failed++; $display("FAIL wlead_owner: got %b want 1", owner); end
    run_master(0, 0, 1, 32'h0, 0, 64'h0, 0, 32'h180, 1, 0, 6'h01, 0);
    tests_run++; if (rdat[0][0] !== 64'h5A) begin tests_failed++; $display("FAIL wlead_data0: got %h want 5a", rdat[0][0]); end
    tests_run++; if (rdat[0][1] !== 64'hB4) begin tests_failed++; $display("FAIL wlead_data1: got %h want b4", rdat[0][1]); end
  endtask

  task automatic test_read_burst();
    logic [63:0] exp;
    do_reset();
    run_master(0, 0, 1, 32'h0, 0, 64'h0, 0, 32'h200, 7, 1, 6'h07, 0);
    tests_run++; if (to_flag[0]) begin tests_failed++; $display("FAIL burst_timeout: got 1 want 0"); end
    tests_run++; if (rbeats[0] != 8) begin tests_failed++; $display("FAIL burst_beats: got %0d want 8", rbeats[0]); end
    tests_run++; if (rlast_cnt[0] != 1 || rlast_bad[0]) begin tests_failed++; $display("FAIL burst_rlast: count %0d misplaced %b want 1/0", rlast_cnt[0], rlast_bad[0]); end
    for (int k = 0; k < 8; k++) begin
      exp = 64'hD0D0_0000_0000_0040 + 64'(k);
      tests_run++; if (rdat[0][k] !== exp) begin tests_failed++; $display("FAIL burst_data%0d: got %h want %h", k, rdat[0][k], exp); end
    end
  endtask

  task automatic test_reset_mid();
    int whs;
    do_reset();
    m_awid[0] = 6'h01; m_awaddr[0] = 32'h100; m_awlen[0] = 8'd3;
    m_awvalid[0] = 1; m_wvalid[0] = 1; m_wlast[0] = 0; m_wdata[0] = 64'hAA; m_bready[0] = 1;
    whs = 0;
    for (int t = 0; t < 50 && whs < 1; t++) begin
      @(negedge clk);
      if (m_wvalid[0] && m_wready[0]) whs++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    tests_run++; if (whs != 1 || m_wready[0] !== 1'b1 || busy !== 1'b1) begin
      tests_failed++; $display("FAIL midrst_setup: beats %0d wready %b busy %b want 1/1/1", whs, m_wready[0], busy);
    end
    rstn = 0;
    #1;
    tests_run++; if (m_wready[0] !== 1'b0 || m_awready[0] !== 1'b0 || m_bvalid[0] !== 1'b0) begin
      tests_failed++; $display("FAIL midrst_master: wready %b awready %b bvalid %b want 0", m_wready[0], m_awready[0], m_bvalid[0]);
    end
    tests_run++; if (s_wvalid !== 1'b0 || s_awvalid !== 1'b0) begin
      tests_failed++; $display("FAIL midrst_slave: wvalid %b awvalid %b want 0", s_wvalid, s_awvalid);
    end
    tests_run++; if (busy !== 1'b0 || owner !== 1'b0) begin
      tests_failed++; $display("FAIL midrst_status: busy %b owner %b want 0/0", busy, owner);
    end
    clear_master(0);
    @(posedge clk); #2 rstn = 1;
    @(posedge clk); #1;
    fork
      run_master(0, 0, 1, 32'h0, 0, 64'h0, 0, 32'h220, 0, 0, 6'h02, 0);
      run_master(1, 0, 1, 32'h0, 0, 64'h0, 0, 32'h228, 0, 0, 6'h03, 0);
    join
    tests_run++; if (to_flag[0] || to_flag[1]) begin tests_failed++; $display("FAIL midrst_timeout: got %b%b want 00", to_flag[1], to_flag[0]); end
    tests_run++; if (!(ar_cyc[0] < ar_cyc[1])) begin tests_failed++; $display("FAIL midrst_rrptr: m0 ar cyc %0d m1 ar cyc %0d want m0 first", ar_cyc[0], ar_cyc[1]); end
    tests_run++; if (rdat[1][0] !== 64'hD0D0_0000_0000_0045) begin tests_failed++; $display("FAIL midrst_m1_data: got %h want d0d0000000000045", rdat[1][0]); end
  endtask

  initial begin
    clear_master(0); clear_master(1);
    test_reset();
    test_single_write();
    test_round_robin();
    test_rw_alternate();
    test_w_before_aw();
    test_read_burst();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/swervolf_ram_arb.md
Name: swervolf_ram_arb

Overview:
- Two-master to one-slave AXI4 arbiter in front of the on-chip RAM (axi_mem_wrapper) in the SweRVolf top level.
- Shares the RAM between master 0 (core RAM port from swervolf_core) and master 1 (DMA / debug loader).
- Exactly one transaction in flight at a time, either a write (AW+W+B) or a read (AR+R).
- Grants rotate round-robin between masters; no transaction is ever interleaved or reordered.

Parameters:
- ID_W, 6, AXI ID width on all three ports; IDs pass through unchanged.
- DW, 64, data width; strobe width is DW/8.

Ports:
- clk  in  1  system clock; the single clock for the block.
- rstn  in  1  asynchronous active-low reset.
- i_mN_awid/awaddr/awlen/awsize/awburst/awvalid  in  ID_W/32/8/3/2/1  master N (N=0,1) AW request.
- o_mN_awready  out  1  master N AW accept.
- i_mN_arid/araddr/arlen/arsize/arburst/arvalid  in  ID_W/32/8/3/2/1  master N AR request.
- o_mN_arready  out  1  master N AR accept.
- i_mN_wdata/wstrb/wlast/wvalid  in  DW/DW/8/1/1  master N write data.
- o_mN_wready  out  1  master N W accept.
- o_mN_bid/bresp/bvalid  out  ID_W/2/1  master N write response.
- i_mN_bready  in  1  master N B accept.
- o_mN_rid/rdata/rresp/rlast/rvalid  out  ID_W/DW/2/1/1  master N read data.
- i_mN_rready  in  1  master N R accept.
- o_s_* / i_s_*  mirror  same widths  slave-side copy of every channel above, prefixed o_s_ (slave inputs) or i_s_ (slave outputs), connected to the RAM.
- o_busy  out  1  high while the FSM is in any state other than IDLE.
- o_owner  out  1  index of the master that holds the current grant.

Behaviour:
- Reset (async, rstn=0): FSM goes to IDLE; rr_ptr=0; aw_done=0; w_done=0; all valid/ready outputs on every port are 0; o_busy=0; o_owner=0.
- FSM states: IDLE, WR, WR_RESP, RD.
- IDLE, request detection:
  - Master N requests if awvalid or arvalid is high.
  - If only one master requests, it wins.
  - If both request, master rr_ptr wins.
- IDLE, read/write choice within the winning master:
  - If both awvalid and arvalid are high, choose the opposite of that master's last op (per-master last_op bit, reset to read, so the first pick is write).
  - Otherwise choose whichever is valid.
- IDLE, grant: register owner and op, then go to WR or RD.
  - Arbitration costs 1 cycle; no handshake completes on any channel in IDLE.
  - rr_ptr flips to the other master on every grant.
- WR state:
  - Owner AW is combinationally connected to slave AW until aw_done.
  - Owner W is connected to slave W until the wlast beat has handshaken (w_done).
  - AW and W proceed independently; AW and W completing in the same cycle is legal.
  - When aw_done and w_done are both set, go to WR_RESP.
- WR_RESP: slave B is routed to the owner. On bvalid&bready: clear aw_done and w_done, return to IDLE.
- RD: owner AR is routed to the slave until accepted; slave R is routed to the owner. On a handshake with rlast=1, return to IDLE.
- The non-owner master always sees awready=arready=wready=0 and bvalid=rvalid=0.
- All slave valids are 0 in IDLE and on channels not in use.
- Response payloads are passed through unmodified; no IDs are remapped.
- A W beat presented before its AW, or while the master is not granted, waits with wready=0.
- Back-to-back: minimum gap between a completing B/R and the next AW/AR accept is 1 cycle (the IDLE cycle).
- Reset asserted mid-transaction aborts it immediately. The slave must be reset by the same rstn.

Test Plan:
- Single write, m0: awaddr=0x100, awlen=1, beats 0x11/0x22 with wlast on beat 2 -> slave sees exactly 2 W beats; o_m0_bvalid with bresp=0; o_busy high from cycle after awvalid until the B handshake; m1 sees no activity.
- Simultaneous m0 AR and m1 AR after reset -> m0 granted first. m1 AR is accepted only after m0's rlast handshake plus the 1-cycle IDLE gap. The next simultaneous pair goes to m1 first.
- m0 holds awvalid and arvalid together -> the write completes first, then the read. Over 4 alternating grants the ops alternate W,R,W,R.
- m1 wvalid asserted 3 cycles before its awvalid -> o_m1_wready stays 0 until the grant. The write completes with correct data at awaddr.
- Read burst arlen=7 with m0 rready toggling every other cycle -> 8 beats delivered in order, rlast only on beat 8, no beat lost or duplicated.
- rstn pulled low during W beat 2 of 4 -> all outputs 0 in the same cycle (async). After release the FSM is in IDLE with rr_ptr=0, and a new m1 read completes normally.
